// File: rtl/counter_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_driver
// Brief    : Turns queued LOAD / COUNT_UP / COUNT_DOWN / HOLD commands into
//            cycle-accurate control of an up/down counter, and checks the
//            counter's outputs against an internal reference model.
// Revision : 1.0  initial release
// ============================================================================
module counter_cmd_driver #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              load_n,
    output logic              up_down,
    output logic              ce,
    output logic [WIDTH-1:0]  data_load,
    input  logic [WIDTH-1:0]  count_out,
    input  logic              max_count,
    input  logic              zero,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                load_n_q, load_n_d;
    logic                up_down_q, up_down_d;
    logic                ce_q, ce_d;
    logic [WIDTH-1:0]    data_load_q, data_load_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    exp_cnt_q, exp_cnt_d;
    logic                model_valid_q, model_valid_d;
    logic                err_q, err_d;
    logic                model_mismatch;

    // Control FSM and all registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            steps_q     <= '0;
            cmd_ready_q <= 1'b1;
            load_n_q    <= 1'b1;
            up_down_q   <= 1'b1;
            ce_q        <= 1'b0;
            data_load_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            cmd_ready_q <= cmd_ready_d;
            load_n_q    <= load_n_d;
            up_down_q   <= up_down_d;
            ce_q        <= ce_d;
            data_load_q <= data_load_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so the registered values line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        cmd_ready_d = cmd_ready_q;
        load_n_d    = 1'b1;
        up_down_d   = up_down_q;
        ce_d        = 1'b0;
        data_load_d = data_load_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d     = S_LOAD;
                            load_n_d    = 1'b0;
                            data_load_d = cmd_data;
                            cmd_ready_d = 1'b0;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_steps != '0) begin
                                state_d     = S_COUNT;
                                ce_d        = 1'b1;
                                up_down_d   = (cmd_op == OP_UP);
                                steps_d     = cmd_steps;
                                cmd_ready_d = 1'b0;
                            end else begin
                                // Zero-length command completes with no activity.
                                done_d = 1'b1;
                            end
                        end
                        default: begin
                            if (cmd_steps != '0) begin
                                state_d     = S_HOLD;
                                steps_d     = cmd_steps;
                                cmd_ready_d = 1'b0;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                cmd_ready_d = 1'b1;
            end
            S_COUNT, S_HOLD: begin
                // steps_q holds the drive cycles remaining including this one.
                steps_d = steps_q - STEP_ONE;
                if (steps_q == STEP_ONE) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end else begin
                    ce_d = (state_q == S_COUNT);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // Compare the live counter against the model once a load has synchronised it.
    always_comb begin
        model_mismatch = 1'b0;
        if (model_valid_q) begin
            model_mismatch = (count_out != exp_cnt_q)
                          || (max_count != (exp_cnt_q == CNT_MAX))
                          || (zero      != (exp_cnt_q == '0));
        end
    end

    // Reference model next state: mirrors the counter's load/step contract.
    always_comb begin
        exp_cnt_d     = exp_cnt_q;
        model_valid_d = model_valid_q;
        err_d         = err_q | model_mismatch;
        if (!load_n_q) begin
            exp_cnt_d     = data_load_q;
            model_valid_d = 1'b1;
        end else if (ce_q) begin
            exp_cnt_d = up_down_q ? (exp_cnt_q + CNT_ONE) : (exp_cnt_q - CNT_ONE);
        end
    end

    // Reference model and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt_q     <= '0;
            model_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            exp_cnt_q     <= exp_cnt_d;
            model_valid_q <= model_valid_d;
            err_q         <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign load_n    = load_n_q;
    assign up_down   = up_down_q;
    assign ce        = ce_q;
    assign data_load = data_load_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_driver
// Brief    : Directed, table-driven bench for counter_cmd_driver with a
//            behavioural 4-bit counter attached to the control port.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_cmd_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_steps;
    logic       load_n;
    logic       up_down;
    logic       ce;
    logic [3:0] data_load;
    logic [3:0] count_out;
    logic       max_count;
    logic       zero;
    logic       done;
    logic       err;

    // Behavioural counter with an override used to inject a bad value.
    logic [3:0] cnt_r;
    logic       force_en;
    logic [3:0] force_val;

    int n_vec = 0;
    int n_err = 0;

    counter_cmd_driver #(.WIDTH(4), .STEP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Conforming counter: load has priority over count enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_r <= 4'h0;
        else if (!load_n)  cnt_r <= data_load;
        else if (ce)       cnt_r <= up_down ? cnt_r + 4'h1 : cnt_r - 4'h1;
    end

    assign count_out = force_en ? force_val : cnt_r;
    assign max_count = (count_out == 4'hF);
    assign zero      = (count_out == 4'h0);

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        int         steps;
        int         e_ld;    // cycles with load_n low
        int         e_ce;    // cycles with ce high
        int         e_done;  // cycle index (1 = cycle after accept) of done
        int         e_cnt;   // counter value in the done cycle
        int         e_ud;    // up_down in the done cycle
        int         e_err;   // err in the done cycle
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller is just past a negedge. Presents one command, follows it to done
    // (bounded), then returns in the done cycle so the next command can be
    // accepted back-to-back.
    task automatic run_cmd(input vec_t v, input string tag);
        int   ld;
        int   cen;
        int   dc;
        logic bad;
        ld  = 0;
        cen = 0;
        dc  = -1;
        bad = 1'b0;
        chk({tag, ".ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_steps = 8'(v.steps);
        @(posedge clk);
        #1;
        // Scramble fields after accept; they must have no further effect.
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_data  = ~v.data;
        cmd_steps = 8'(v.steps + 3);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!load_n) begin
                ld++;
                if (ce || data_load != v.data) bad = 1'b1;
            end
            if (ce) begin
                cen++;
                if (!load_n || up_down != v.e_ud[0]) bad = 1'b1;
            end
            if (done) begin
                dc = k;
                if (!cmd_ready) bad = 1'b1;
                break;
            end
            if (cmd_ready) bad = 1'b1;
        end
        chk({tag, ".load_cycles"}, ld, v.e_ld);
        chk({tag, ".ce_cycles"},   cen, v.e_ce);
        chk({tag, ".done_cycle"},  dc, v.e_done);
        chk({tag, ".count"},       int'(count_out), v.e_cnt);
        chk({tag, ".up_down"},     int'(up_down), v.e_ud);
        chk({tag, ".err"},         int'(err), v.e_err);
        chk({tag, ".ctl_ok"},      int'(bad), 0);
    endtask

    vec_t hv;
    int   ce_seen;

    initial begin
        //            op     data  steps ld ce done cnt ud err
        tbl[0]  = '{2'd0, 4'h5,   0,  1, 0,   2,  5, 1, 0};
        tbl[1]  = '{2'd0, 4'hE,   0,  1, 0,   2, 14, 1, 0};
        tbl[2]  = '{2'd1, 4'h0,   3,  0, 3,   4,  1, 1, 0};
        tbl[3]  = '{2'd0, 4'h2,   0,  1, 0,   2,  2, 1, 0};
        tbl[4]  = '{2'd2, 4'h0,   4,  0, 4,   5, 14, 0, 0};
        tbl[5]  = '{2'd3, 4'h0,   5,  0, 0,   6, 14, 0, 0};
        tbl[6]  = '{2'd1, 4'h0,   0,  0, 0,   1, 14, 0, 0};
        tbl[7]  = '{2'd0, 4'h0,   0,  1, 0,   2,  0, 0, 0};
        tbl[8]  = '{2'd1, 4'h0, 255,  0, 255, 256, 15, 1, 0};
        tbl[9]  = '{2'd2, 4'h0,   1,  0, 1,   2, 14, 0, 0};
        tbl[10] = '{2'd3, 4'h0,   0,  0, 0,   1, 14, 0, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 4'h0;
        cmd_steps = 8'd0;
        force_en  = 1'b0;
        force_val = 4'h0;

        #12;
        chk("rst.ready",     int'(cmd_ready), 1);
        chk("rst.load_n",    int'(load_n),    1);
        chk("rst.ce",        int'(ce),        0);
        chk("rst.up_down",   int'(up_down),   1);
        chk("rst.data_load", int'(data_load), 0);
        chk("rst.done",      int'(done),      0);
        chk("rst.err",       int'(err),       0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        // Mismatch injection: one bad sample sets err, which then sticks.
        hv = '{2'd0, 4'h7, 0, 1, 0, 2, 7, 0, 0};
        run_cmd(hv, "inj.load7");
        force_en  = 1'b1;
        force_val = 4'h8;
        chk("inj.err_before_edge", int'(err), 0);
        @(negedge clk);
        force_en = 1'b0;
        chk("inj.err_rise", int'(err), 1);
        hv = '{2'd1, 4'h0, 2, 0, 2, 3, 9, 1, 1};
        run_cmd(hv, "inj.up2");
        hv = '{2'd3, 4'h0, 1, 0, 0, 2, 9, 1, 1};
        run_cmd(hv, "inj.hold1");
        rst_n = 1'b0;
        #1;
        chk("inj.err_cleared", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a long count.
        hv = '{2'd0, 4'h0, 0, 1, 0, 2, 0, 1, 0};
        run_cmd(hv, "mid.load0");
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_steps = 8'd200;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ce_seen   = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (ce && !done) ce_seen++;
        end
        chk("mid.ce_before_reset", ce_seen, 50);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_ce",     int'(ce),        0);
        chk("mid.rst_load_n", int'(load_n),    1);
        chk("mid.rst_ready",  int'(cmd_ready), 1);
        chk("mid.rst_done",   int'(done),      0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Model must be invalid now: a bogus counter value is not flagged.
        force_en  = 1'b1;
        force_val = 4'hA;
        @(negedge clk);
        chk("mid.post_done",  int'(done), 0);
        chk("mid.post_ce",    int'(ce),   0);
        @(negedge clk);
        chk("mid.model_invalid_err", int'(err), 0);
        force_en = 1'b0;
        hv = '{2'd0, 4'h3, 0, 1, 0, 2, 3, 1, 0};
        run_cmd(hv, "mid.load3");
        hv = '{2'd1, 4'h0, 1, 0, 1, 2, 4, 1, 0};
        run_cmd(hv, "mid.up1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
